// File: rtl/ex_operand_if.sv
// ID/EX operand-stage bus: decode inputs, pipeline control, MEM/WB forwarding taps and ALU-facing outputs.
interface ex_operand_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned OP_W   = 3
);
   logic              id_valid;
   logic              stall;
   logic              flush;
   logic [REG_AW-1:0] id_rs_addr;
   logic [REG_AW-1:0] id_rt_addr;
   logic [REG_AW-1:0] id_rd_addr;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [DATA_W-1:0] id_imm;
   logic              id_alu_src;
   logic [OP_W-1:0]   id_alu_op;
   logic              id_reg_write;

   logic              mem_reg_write;
   logic [REG_AW-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_result;
   logic              wb_reg_write;
   logic [REG_AW-1:0] wb_rd_addr;
   logic [DATA_W-1:0] wb_result;

   logic              ex_valid;
   logic [DATA_W-1:0] ex_A;
   logic [DATA_W-1:0] ex_B;
   logic [OP_W-1:0]   ex_alu_op;
   logic [DATA_W-1:0] ex_store_data;
   logic [REG_AW-1:0] ex_rd_addr;
   logic              ex_reg_write;

   modport master (
      output id_valid, stall, flush, id_rs_addr, id_rt_addr, id_rd_addr,
             id_rs_data, id_rt_data, id_imm, id_alu_src, id_alu_op, id_reg_write,
             mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
      input  ex_valid, ex_A, ex_B, ex_alu_op, ex_store_data, ex_rd_addr, ex_reg_write
   );

   modport slave (
      input  id_valid, stall, flush, id_rs_addr, id_rt_addr, id_rd_addr,
             id_rs_data, id_rt_data, id_imm, id_alu_src, id_alu_op, id_reg_write,
             mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
      output ex_valid, ex_A, ex_B, ex_alu_op, ex_store_data, ex_rd_addr, ex_reg_write
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB result forwarding, stall hold and flush bubble insertion.
module ex_operand_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned OP_W   = 3
) (
   input  logic         clk,
   input  logic         rst,
   ex_operand_if.slave  bus
);
   logic              valid_q;
   logic              reg_write_q;
   logic [REG_AW-1:0] rs_addr_q;
   logic [REG_AW-1:0] rt_addr_q;
   logic [REG_AW-1:0] rd_addr_q;
   logic [DATA_W-1:0] rs_q;
   logic [DATA_W-1:0] rt_q;
   logic [DATA_W-1:0] imm_q;
   logic              alu_src_q;
   logic [OP_W-1:0]   alu_op_q;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // Stage register: flush beats stall beats load; stall refreshes operands from the forward path
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         rd_addr_q   <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         imm_q       <= '0;
         alu_src_q   <= 1'b0;
         alu_op_q    <= '0;
      end else if (bus.flush) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
      end else if (bus.stall) begin
         rs_q <= fwd_rs;
         rt_q <= fwd_rt;
      end else begin
         valid_q     <= bus.id_valid;
         reg_write_q <= bus.id_reg_write & bus.id_valid;
         rs_addr_q   <= bus.id_rs_addr;
         rt_addr_q   <= bus.id_rt_addr;
         rd_addr_q   <= bus.id_rd_addr;
         rs_q        <= bus.id_rs_data;
         rt_q        <= bus.id_rt_data;
         imm_q       <= bus.id_imm;
         alu_src_q   <= bus.id_alu_src;
         alu_op_q    <= bus.id_alu_op;
      end
   end

   // Forwarding: MEM is the youngest producer and wins over WB; r0 is never forwarded
   always_comb begin
      fwd_rs = rs_q;
      fwd_rt = rt_q;
      if (bus.mem_reg_write && (bus.mem_rd_addr == rs_addr_q) && (rs_addr_q != '0))
         fwd_rs = bus.mem_result;
      else if (bus.wb_reg_write && (bus.wb_rd_addr == rs_addr_q) && (rs_addr_q != '0))
         fwd_rs = bus.wb_result;
      if (bus.mem_reg_write && (bus.mem_rd_addr == rt_addr_q) && (rt_addr_q != '0))
         fwd_rt = bus.mem_result;
      else if (bus.wb_reg_write && (bus.wb_rd_addr == rt_addr_q) && (rt_addr_q != '0))
         fwd_rt = bus.wb_result;
   end

   assign bus.ex_valid      = valid_q;
   assign bus.ex_A          = fwd_rs;
   assign bus.ex_B          = alu_src_q ? imm_q : fwd_rt;
   assign bus.ex_alu_op     = alu_op_q;
   assign bus.ex_store_data = fwd_rt;
   assign bus.ex_rd_addr    = rd_addr_q;
   assign bus.ex_reg_write  = reg_write_q & valid_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: load, forwarding priority, r0, stall refresh, flush, immediate select, async reset.
module tb_ex_operand_stage;
   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   ex_operand_if #(.DATA_W(32), .REG_AW(5), .OP_W(3)) bus ();

   ex_operand_stage #(.DATA_W(32), .REG_AW(5), .OP_W(3)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_id(input logic valid, input logic [4:0] rs, input logic [31:0] rs_d,
                          input logic [4:0] rt, input logic [31:0] rt_d, input logic [4:0] rd,
                          input logic [31:0] imm, input logic alu_src, input logic [2:0] op,
                          input logic rw);
      bus.id_valid     = valid;
      bus.id_rs_addr   = rs;
      bus.id_rs_data   = rs_d;
      bus.id_rt_addr   = rt;
      bus.id_rt_data   = rt_d;
      bus.id_rd_addr   = rd;
      bus.id_imm       = imm;
      bus.id_alu_src   = alu_src;
      bus.id_alu_op    = op;
      bus.id_reg_write = rw;
   endtask

   task automatic fwd_idle();
      bus.mem_reg_write = 1'b0;
      bus.mem_rd_addr   = 5'd0;
      bus.mem_result    = 32'h0;
      bus.wb_reg_write  = 1'b0;
      bus.wb_rd_addr    = 5'd0;
      bus.wb_result     = 32'h0;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      bus.stall  = 1'b0;
      bus.flush  = 1'b0;
      load_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 3'b000, 1'b0);
      fwd_idle();

      // Reset state
      #2;
      check("rst_valid",  32'(bus.ex_valid), 32'h0);
      check("rst_rw",     32'(bus.ex_reg_write), 32'h0);
      check("rst_A",      bus.ex_A, 32'h0);
      check("rst_B",      bus.ex_B, 32'h0);
      check("rst_store",  bus.ex_store_data, 32'h0);
      check("rst_op",     32'(bus.ex_alu_op), 32'h0);
      check("rst_rd",     32'(bus.ex_rd_addr), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: plain load, 1-cycle latency
      load_id(1'b1, 5'd5, 32'h10, 5'd6, 32'h20, 5'd7, 32'h0, 1'b0, 3'b000, 1'b1);
      @(posedge clk); #1;
      check("t1_A",     bus.ex_A, 32'h10);
      check("t1_B",     bus.ex_B, 32'h20);
      check("t1_valid", 32'(bus.ex_valid), 32'h1);
      check("t1_rw",    32'(bus.ex_reg_write), 32'h1);
      check("t1_rd",    32'(bus.ex_rd_addr), 32'h7);
      check("t1_store", bus.ex_store_data, 32'h20);

      // 2: MEM beats WB for rs, WB alone forwards, rt from WB
      bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd5; bus.mem_result = 32'hAA;
      bus.wb_reg_write  = 1'b1; bus.wb_rd_addr  = 5'd5; bus.wb_result  = 32'hBB;
      #1; check("t2_A_mem", bus.ex_A, 32'hAA);
      bus.mem_reg_write = 1'b0;
      #1; check("t2_A_wb", bus.ex_A, 32'hBB);
      bus.wb_rd_addr = 5'd6;
      #1;
      check("t2_A_none", bus.ex_A, 32'h10);
      check("t2_B_wb",   bus.ex_B, 32'hBB);
      @(negedge clk);
      fwd_idle();

      // 3: r0 is never forwarded
      load_id(1'b1, 5'd0, 32'h0, 5'd6, 32'h20, 5'd7, 32'h0, 1'b0, 3'b000, 1'b1);
      @(posedge clk); #1;
      bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd0; bus.mem_result = 32'hFF;
      bus.wb_reg_write  = 1'b1; bus.wb_rd_addr  = 5'd0; bus.wb_result  = 32'hEE;
      #1; check("t3_A_r0", bus.ex_A, 32'h0);
      @(negedge clk);
      fwd_idle();

      // 4: two-cycle stall, WB producer for rt retires in first stall cycle only
      load_id(1'b1, 5'd5, 32'h10, 5'd6, 32'h20, 5'd9, 32'h0, 1'b0, 3'b100, 1'b1);
      @(posedge clk); #1;
      check("t4_B_pre", bus.ex_B, 32'h20);
      @(negedge clk);
      bus.stall = 1'b1;
      load_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h99, 5'd3, 32'h0, 1'b0, 3'b001, 1'b1);
      bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd6; bus.wb_result = 32'h77;
      #1; check("t4_B_c1", bus.ex_B, 32'h77);
      @(posedge clk); #1;
      check("t4_op_hold", 32'(bus.ex_alu_op), 32'h4);
      check("t4_rd_hold", 32'(bus.ex_rd_addr), 32'h9);
      @(negedge clk);
      fwd_idle();
      #1; check("t4_B_c2", bus.ex_B, 32'h77);
      @(posedge clk); #1;
      check("t4_B_after", bus.ex_B, 32'h77);
      check("t4_A_hold",  bus.ex_A, 32'h10);

      // 5: flush with stall still flushes
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      check("t5_valid", 32'(bus.ex_valid), 32'h0);
      check("t5_rw",    32'(bus.ex_reg_write), 32'h0);
      @(negedge clk);
      bus.flush = 1'b0;
      bus.stall = 1'b0;

      // invalid instruction never writes even with id_reg_write set
      load_id(1'b0, 5'd5, 32'h10, 5'd6, 32'h20, 5'd7, 32'h0, 1'b0, 3'b000, 1'b1);
      @(posedge clk); #1;
      check("inv_valid", 32'(bus.ex_valid), 32'h0);
      check("inv_rw",    32'(bus.ex_reg_write), 32'h0);

      // 6: immediate on B, store data keeps forwarded rt, MEM beats WB on rt
      @(negedge clk);
      load_id(1'b1, 5'd5, 32'h10, 5'd6, 32'h20, 5'd4, 32'h1234, 1'b1, 3'b110, 1'b1);
      @(posedge clk); #1;
      bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd6; bus.mem_result = 32'h55;
      bus.wb_reg_write  = 1'b1; bus.wb_rd_addr  = 5'd6; bus.wb_result  = 32'h66;
      #1;
      check("t6_B_imm", bus.ex_B, 32'h1234);
      check("t6_store", bus.ex_store_data, 32'h55);
      check("t6_op",    32'(bus.ex_alu_op), 32'h6);
      check("t6_valid", 32'(bus.ex_valid), 32'h1);
      fwd_idle();

      // 7: async reset with no clock edge
      #1; rst = 1'b1;
      #1;
      check("t7_valid", 32'(bus.ex_valid), 32'h0);
      check("t7_A",     bus.ex_A, 32'h0);
      check("t7_B",     bus.ex_B, 32'h0);
      check("t7_rw",    32'(bus.ex_reg_write), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
